// File: rtl/mac_unit_core_pkg.sv
// -----------------------------------------------------------------------------
// mac_unit_core_pkg
// Shared widths and the full-adder cell used by the accumulator adder.
//   OPERAND_W : width of the a/b operands
//   PRODUCT_W : width of the a*b product and of the bypass addend
//   ACC_W     : width of the wrapping accumulator
// -----------------------------------------------------------------------------
package mac_unit_core_pkg;

    localparam int OPERAND_W = 2;
    localparam int PRODUCT_W = 4;
    localparam int ACC_W     = 8;

    // Full-adder cell, split into its sum and carry halves so the final
    // stage of the ripple chain can use only the sum (the carry-out of the
    // accumulator is discarded because the accumulator wraps silently).
    function automatic logic fa_sum(input logic x, input logic y, input logic cin);
        return x ^ y ^ cin;
    endfunction

    function automatic logic fa_carry(input logic x, input logic y, input logic cin);
        return (x & y) | (x & cin) | (y & cin);
    endfunction

endpackage

// File: rtl/mac_unit_core_multiplier_2x2.sv
// -----------------------------------------------------------------------------
// multiplier_2x2
// Purely combinational 2-bit x 2-bit unsigned multiplier built as an AND
// array with two half adders.
//   a : 2-bit multiplicand
//   b : 2-bit multiplier
//   p : 4-bit product (0..9)
// -----------------------------------------------------------------------------
module multiplier_2x2
    import mac_unit_core_pkg::*;
(
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    output logic [PRODUCT_W-1:0] p
);

    logic pp_a1b0;
    logic pp_a0b1;
    logic pp_a1b1;
    logic carry_col1;

    assign pp_a1b0 = a[1] & b[0];
    assign pp_a0b1 = a[0] & b[1];
    assign pp_a1b1 = a[1] & b[1];

    // Column 0: single partial product.
    assign p[0] = a[0] & b[0];

    // Column 1: half adder of the two cross terms.
    assign p[1]       = pp_a1b0 ^ pp_a0b1;
    assign carry_col1 = pp_a1b0 & pp_a0b1;

    // Column 2/3: half adder of a1b1 with the column-1 carry.
    assign p[2] = pp_a1b1 ^ carry_col1;
    assign p[3] = pp_a1b1 & carry_col1;

endmodule

// File: rtl/mac_unit_core.sv
// -----------------------------------------------------------------------------
// mac_unit_core
// Multiply-accumulate leaf: every rising clk edge adds either a*b or the
// bypass addend zero_input to an 8-bit wrapping accumulator.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-low clear of the accumulator
//   enable     : 1 -> addend is a*b, 0 -> addend is zero_input
//   a, b       : 2-bit unsigned operands
//   zero_input : 4-bit bypass addend (normally 0 so the accumulator holds)
//   out        : registered accumulator value
// -----------------------------------------------------------------------------
module mac_unit_core
    import mac_unit_core_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [OPERAND_W-1:0] a,
    input  logic [OPERAND_W-1:0] b,
    input  logic [PRODUCT_W-1:0] zero_input,
    output logic [ACC_W-1:0]     out
);

    logic [PRODUCT_W-1:0] product;
    logic [PRODUCT_W-1:0] addend_narrow;
    logic [ACC_W-1:0]     addend;
    logic [ACC_W-1:0]     sum_next;
    logic [ACC_W-1:0]     carry;
    logic [ACC_W-1:0]     acc_reg;

    multiplier_2x2 u_multiplier (
        .a (a),
        .b (b),
        .p (product)
    );

    // 4-bit 2:1 selector, one bit slice per position.
    generate
        for (genvar gi = 0; gi < PRODUCT_W; gi++) begin : g_mux
            assign addend_narrow[gi] = enable ? product[gi] : zero_input[gi];
        end
    endgenerate

    assign addend = {{(ACC_W-PRODUCT_W){1'b0}}, addend_narrow};

    // 8-bit ripple-carry adder. The carry out of the top bit is dropped,
    // which gives the mod-256 wrap.
    assign carry[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < ACC_W; gi++) begin : g_adder
            assign sum_next[gi] = fa_sum(acc_reg[gi], addend[gi], carry[gi]);
            if (gi < ACC_W-1) begin : g_carry
                assign carry[gi+1] = fa_carry(acc_reg[gi], addend[gi], carry[gi]);
            end
        end
    endgenerate

    // Accumulator: one async-clear D flip-flop per bit.
    generate
        for (genvar gi = 0; gi < ACC_W; gi++) begin : g_acc
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_reg[gi] <= 1'b0;
                end else begin
                    acc_reg[gi] <= sum_next[gi];
                end
            end
        end
    endgenerate

    assign out = acc_reg;

endmodule

// File: tb/tb_mac_unit_core.sv
module tb_mac_unit_core;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [1:0] a;
    logic [1:0] b;
    logic [3:0] zero_input;
    logic [7:0] out;

    int n_compared   = 0;
    int n_mismatched = 0;
    int acc_model    = 0;

    mac_unit_core dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .a          (a),
        .b          (b),
        .zero_input (zero_input),
        .out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: accumulator as an integer, cleared whenever reset is low.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_model = 0;
        end else begin
            acc_model = (acc_model + (enable ? int'(a) * int'(b) : int'(zero_input))) % 256;
        end
    end

    task automatic check(input string name, input logic [7:0] got, input int expected);
        n_compared++;
        if (got !== expected[7:0]) begin
            n_mismatched++;
            $display("FAIL %s: out=%0d expected=%0d at t=%0t", name, got, expected, $time);
        end else begin
            $display("ok   %s: out=%0d", name, got);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("model", out, acc_model);
    end

    // Apply inputs, take one rising edge, then check a hand-computed value.
    task automatic step(input logic en, input logic [1:0] av, input logic [1:0] bv,
                        input logic [3:0] zv, input int expected, input string name);
        enable = en; a = av; b = bv; zero_input = zv;
        @(posedge clk);
        #1;
        check(name, out, expected);
    endtask

    task automatic do_reset();
        #1 reset = 1'b0;
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0; enable = 1'b1; a = 2'd0; b = 2'd0; zero_input = 4'd0;
        #2;
        check("reset_state", out, 0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Zero operands with enable=1 keep the accumulator at 0.
        for (int i = 0; i < 3; i++) step(1'b1, 2'd0, 2'd0, 4'd0, 0, "zero_ops");

        // Accumulate sequence.
        step(1'b1, 2'd1, 2'd1, 4'd0, 1, "acc_1x1_a");
        step(1'b1, 2'd1, 2'd1, 4'd0, 2, "acc_1x1_b");
        step(1'b1, 2'd2, 2'd2, 4'd0, 6, "acc_2x2");

        // Hold with enable=0, zero_input=0.
        for (int i = 0; i < 3; i++) step(1'b0, 2'd3, 2'd3, 4'd0, 6, "hold");
        step(1'b1, 2'd3, 2'd3, 4'd0, 15, "acc_3x3");

        // Mid-cycle asynchronous reset from 15.
        #2 reset = 1'b0;
        #1 check("async_reset", out, 0);
        #1 reset = 1'b1;

        // Bypass addend.
        step(1'b0, 2'd3, 2'd3, 4'd5, 5,  "bypass_a");
        step(1'b0, 2'd3, 2'd3, 4'd5, 10, "bypass_b");

        // Wrap: 29 x 9 = 261 -> 5.
        do_reset();
        for (int i = 1; i <= 29; i++) begin
            enable = 1'b1; a = 2'd3; b = 2'd3; zero_input = 4'd0;
            @(posedge clk); #1;
            if (i == 28) check("pre_wrap", out, 252);
        end
        check("wrap", out, 5);

        // Reset coincident with a rising edge.
        step(1'b1, 2'd1, 2'd1, 4'd0, 6, "before_coincident");
        @(posedge clk);
        reset = 1'b0;
        #1 check("coincident_reset", out, 0);
        #2 reset = 1'b1;
        step(1'b1, 2'd1, 2'd1, 4'd0, 1, "after_release");

        // Randomized phase, checked by the every-cycle model compare.
        for (int i = 0; i < 400; i++) begin
            enable     = 1'($urandom_range(0, 1));
            a          = 2'($urandom_range(0, 3));
            b          = 2'($urandom_range(0, 3));
            zero_input = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
            if ($urandom_range(0, 39) == 0) begin
                #2 reset = 1'b0;
                #1 check("rand_reset", out, 0);
                reset = 1'b1;
            end
            @(posedge clk); #1;
        end

        @(negedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
